// File: rtl/sound_effect_arbiter.sv
// -----------------------------------------------------------------------------
// sound_effect_arbiter
//
// Fixed-priority scheduler that shares one sample ROM and one codec path
// among N_REQ sound requesters (index 0 = highest priority). Request pulses
// are latched into `pending`. The winning sound's address range is walked
// one word per codec sample tick, and a mono 16-bit sample stream is
// presented to the codec driver.
//
// Ports
//   Clk           system clock, rising edge
//   Reset_n       asynchronous active-low reset
//   req           request pulses, OR-ed into pending every cycle
//   stop          synchronous abort of the playing sound and all pending ones
//   base_addrs    start address of sound i in [i*ADDR_W +: ADDR_W]
//   lengths       sample count of sound i, same slicing
//   sample_tick   one-cycle pulse per codec sample
//   sound_data    ROM read data, valid one cycle after sound_address changes
//   sound_address ROM read address
//   sample_out    sample presented to the codec (left = right)
//   busy          high while a sound is playing
//   cur_id        index of the sound being played
//   pending       latched requests not yet granted
//   done          one-cycle pulse when sound i finishes naturally
//   fsm_state     debug view of the controller state (0 = IDLE, 1 = PLAY)
// -----------------------------------------------------------------------------
module sound_effect_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 18,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic                    stop,
  input  logic [N_REQ*ADDR_W-1:0] base_addrs,
  input  logic [N_REQ*ADDR_W-1:0] lengths,
  input  logic                    sample_tick,
  input  logic [15:0]             sound_data,
  output logic [ADDR_W-1:0]       sound_address,
  output logic [15:0]             sample_out,
  output logic                    busy,
  output logic [ID_W-1:0]         cur_id,
  output logic [N_REQ-1:0]        pending,
  output logic [N_REQ-1:0]        done,
  output logic                    fsm_state
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [15:0]       sample_q, sample_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  done_q, done_d;

  logic [N_REQ-1:0]  eligible;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ADDR_W-1:0] grant_base;
  logic [ADDR_W-1:0] grant_len;

  // In IDLE every pending request may win. While playing, only requests of
  // equal or higher priority than the current sound may cut in; the same
  // index retriggers the sound from its start.
  always_comb begin
    eligible = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if ((state_q == IDLE) || (ID_W'(j) <= id_q)) begin
        eligible[j] = pending_q[j];
      end
    end
  end

  // Lowest eligible index wins. The loop scans downward, so the last hit
  // is the lowest index.
  always_comb begin
    grant_vld  = 1'b0;
    grant_id   = '0;
    grant_base = '0;
    grant_len  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (eligible[j]) begin
        grant_vld  = 1'b1;
        grant_id   = ID_W'(j);
        grant_base = base_addrs[j*ADDR_W +: ADDR_W];
        grant_len  = lengths[j*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    sample_d  = sample_q;
    done_d    = '0;
    pending_d = pending_q | req;

    if (stop) begin
      // Abort everything. The codec goes silent right away when a sound was
      // cut off; in IDLE a tick silences it as usual.
      pending_d = '0;
      state_d   = IDLE;
      if ((state_q == PLAY) || sample_tick) begin
        sample_d = '0;
      end
    end else begin
      if (sample_tick) begin
        if (state_q == PLAY) begin
          sample_d = sound_data;
          addr_d   = addr_q + ADDR_W'(1);
          rem_d    = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d        = IDLE;
            done_d[id_q]   = 1'b1;
          end
        end else begin
          sample_d = '0;
        end
      end

      // A grant overrides the tick's address/length bookkeeping and any
      // completion of the preempted sound (which is dropped silently). The
      // sample already latched from the old sound this cycle is kept.
      if (grant_vld) begin
        pending_d[grant_id] = 1'b0;
        done_d              = '0;
        if (grant_len == '0) begin
          // Nothing to play: report completion at once and leave the path
          // free for the next request.
          done_d[grant_id] = 1'b1;
          state_d          = IDLE;
        end else begin
          id_d    = grant_id;
          addr_d  = grant_base;
          rem_d   = grant_len;
          state_d = PLAY;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q    <= '0;
      rem_q     <= '0;
      id_q      <= '0;
      sample_q  <= '0;
      pending_q <= '0;
      done_q    <= '0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      sample_q  <= sample_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign sound_address = addr_q;
  assign sample_out    = sample_q;
  assign busy          = (state_q == PLAY);
  assign cur_id        = id_q;
  assign pending       = pending_q;
  assign done          = done_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_sound_effect_arbiter.sv
module tb_sound_effect_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 18;

  // ---------------------------------------------------------------- clock/reset
  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------- DUT signals
  logic [N_REQ-1:0]        req         = '0;
  logic                    stop        = 1'b0;
  logic                    sample_tick = 1'b0;
  logic [N_REQ*ADDR_W-1:0] base_addrs;
  logic [N_REQ*ADDR_W-1:0] lengths;
  logic [15:0]             sound_data  = '0;
  logic [ADDR_W-1:0]       sound_address;
  logic [15:0]             sample_out;
  logic                    busy;
  logic [1:0]              cur_id;
  logic [N_REQ-1:0]        pending;
  logic [N_REQ-1:0]        done;
  logic                    fsm_state;

  logic [ADDR_W-1:0] base_a [N_REQ];
  logic [ADDR_W-1:0] len_a  [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      base_addrs[i*ADDR_W +: ADDR_W] = base_a[i];
      lengths[i*ADDR_W +: ADDR_W]    = len_a[i];
    end
  end

  sound_effect_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .req           (req),
    .stop          (stop),
    .base_addrs    (base_addrs),
    .lengths       (lengths),
    .sample_tick   (sample_tick),
    .sound_data    (sound_data),
    .sound_address (sound_address),
    .sample_out    (sample_out),
    .busy          (busy),
    .cur_id        (cur_id),
    .pending       (pending),
    .done          (done),
    .fsm_state     (fsm_state)
  );

  // ROM model: one-cycle registered read of a fixed pattern.
  function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
    return a[15:0] * 16'd37 + 16'h1234;
  endfunction

  always @(posedge Clk) sound_data <= rom_word(sound_address);

  // Count done pulses per requester, sampled away from the active edge.
  int done_cnt [N_REQ] = '{default: 0};
  always @(negedge Clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (done[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic b, input logic [ADDR_W-1:0] a,
                             input logic [1:0] id, input logic [3:0] p, input logic [3:0] d);
    check($sformatf("%s.busy", tag),    32'(busy),          32'(b));
    check($sformatf("%s.addr", tag),    32'(sound_address), 32'(a));
    check($sformatf("%s.cur_id", tag),  32'(cur_id),        32'(id));
    check($sformatf("%s.pending", tag), 32'(pending),       32'(p));
    check($sformatf("%s.done", tag),    32'(done),          32'(d));
  endtask

  // ---------------------------------------------------------------- drivers
  // Inputs are held for one clock; outputs are inspected 1 ns after the edge.
  task automatic step(input logic [3:0] r, input logic s, input logic t);
    req         = r;
    stop        = s;
    sample_tick = t;
    @(posedge Clk);
    #1;
    req         = '0;
    stop        = 1'b0;
    sample_tick = 1'b0;
  endtask

  // Each tick is preceded by a quiet cycle, keeping ticks two cycles apart.
  task automatic play_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b1);
    end
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [3:0]        req;
    logic              stop;
    logic              tick;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       sample;
    logic [1:0]        id;
    logic [3:0]        pend;
    logic [3:0]        done;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Single sound: base[1]=100, len[1]=3, one pulse on req[1].
    vecs[0]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 18'd0,   16'd0,          2'd0, 4'b0010, 4'b0000};
    vecs[1]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 18'd100, 16'd0,          2'd1, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 18'd100, 16'd0,          2'd1, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 18'd101, rom_word(18'd100), 2'd1, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 18'd101, rom_word(18'd100), 2'd1, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 18'd102, rom_word(18'd101), 2'd1, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 18'd102, rom_word(18'd101), 2'd1, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 18'd103, rom_word(18'd102), 2'd1, 4'b0000, 4'b0010};
    vecs[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 18'd103, rom_word(18'd102), 2'd1, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 18'd103, rom_word(18'd102), 2'd1, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0000, 1'b0, 1'b1, 1'b0, 18'd103, 16'd0,          2'd1, 4'b0000, 4'b0000};

    base_a[0] = 18'd1000; len_a[0] = 18'd5;
    base_a[1] = 18'd100;  len_a[1] = 18'd3;
    base_a[2] = 18'd2000; len_a[2] = 18'd2;
    base_a[3] = 18'd3000; len_a[3] = 18'd2;

    // ---- reset
    repeat (2) @(posedge Clk);
    #1;
    check_state("reset", 1'b0, 18'd0, 2'd0, 4'b0000, 4'b0000);
    check("reset.sample", 32'(sample_out), 32'd0);
    check("reset.fsm_state", 32'(fsm_state), 32'd0);
    Reset_n = 1'b1;
    step(4'b0000, 1'b0, 1'b0);

    // ---- single sound, table-driven
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].req, vecs[i].stop, vecs[i].tick);
      check_state($sformatf("single[%0d]", i), vecs[i].busy, vecs[i].addr,
                  vecs[i].id, vecs[i].pend, vecs[i].done);
      check($sformatf("single[%0d].sample", i), 32'(sample_out), 32'(vecs[i].sample));
    end
    check("single.done_cnt1", 32'(done_cnt[1]), 32'd1);

    // ---- queued priority: req[2] and req[3] together
    step(4'b1100, 1'b0, 1'b0);
    check_state("queue.latch", 1'b0, 18'd103, 2'd1, 4'b1100, 4'b0000);
    step(4'b0000, 1'b0, 1'b0);
    check_state("queue.grant2", 1'b1, 18'd2000, 2'd2, 4'b1000, 4'b0000);
    play_ticks(1);
    check_state("queue.tick2a", 1'b1, 18'd2001, 2'd2, 4'b1000, 4'b0000);
    check("queue.sample2a", 32'(sample_out), 32'(rom_word(18'd2000)));
    play_ticks(1);
    check_state("queue.done2", 1'b0, 18'd2002, 2'd2, 4'b1000, 4'b0100);
    step(4'b0000, 1'b0, 1'b0);
    check_state("queue.grant3", 1'b1, 18'd3000, 2'd3, 4'b0000, 4'b0000);
    play_ticks(2);
    check_state("queue.done3", 1'b0, 18'd3002, 2'd3, 4'b0000, 4'b1000);
    step(4'b0000, 1'b0, 1'b0);
    check("queue.done_cnt2", 32'(done_cnt[2]), 32'd1);
    check("queue.done_cnt3", 32'(done_cnt[3]), 32'd1);

    // ---- preemption of sound 2 by sound 0, then deferral of sound 3
    len_a[2] = 18'd10;
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_state("preempt.start2", 1'b1, 18'd2000, 2'd2, 4'b0000, 4'b0000);
    play_ticks(4);
    check_state("preempt.tick4", 1'b1, 18'd2004, 2'd2, 4'b0000, 4'b0000);
    step(4'b0001, 1'b0, 1'b0);
    check_state("preempt.latch0", 1'b1, 18'd2004, 2'd2, 4'b0001, 4'b0000);
    step(4'b0000, 1'b0, 1'b0);
    check_state("preempt.grant0", 1'b1, 18'd1000, 2'd0, 4'b0000, 4'b0000);
    step(4'b1000, 1'b0, 1'b0);
    check_state("defer.latch3", 1'b1, 18'd1000, 2'd0, 4'b1000, 4'b0000);
    play_ticks(4);
    check_state("defer.tick4", 1'b1, 18'd1004, 2'd0, 4'b1000, 4'b0000);
    check("defer.sample", 32'(sample_out), 32'(rom_word(18'd1003)));
    play_ticks(1);
    check_state("defer.done0", 1'b0, 18'd1005, 2'd0, 4'b1000, 4'b0001);
    step(4'b0000, 1'b0, 1'b0);
    check_state("defer.grant3", 1'b1, 18'd3000, 2'd3, 4'b0000, 4'b0000);
    play_ticks(2);
    check_state("defer.done3", 1'b0, 18'd3002, 2'd3, 4'b0000, 4'b1000);
    step(4'b0000, 1'b0, 1'b0);
    check("preempt.no_done2", 32'(done_cnt[2]), 32'd1);
    check("defer.done_cnt0", 32'(done_cnt[0]), 32'd1);
    check("defer.done_cnt3", 32'(done_cnt[3]), 32'd2);

    // ---- zero-length sound
    len_a[1] = 18'd0;
    step(4'b0010, 1'b0, 1'b0);
    check_state("zero.latch", 1'b0, 18'd3002, 2'd3, 4'b0010, 4'b0000);
    step(4'b0000, 1'b0, 1'b0);
    check_state("zero.done", 1'b0, 18'd3002, 2'd3, 4'b0000, 4'b0010);
    step(4'b0000, 1'b0, 1'b0);
    check_state("zero.after", 1'b0, 18'd3002, 2'd3, 4'b0000, 4'b0000);
    check("zero.done_cnt1", 32'(done_cnt[1]), 32'd2);

    // ---- stop mid-sound, with a request arriving in the same cycle
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_state("stop.start0", 1'b1, 18'd1000, 2'd0, 4'b0000, 4'b0000);
    play_ticks(2);
    check("stop.sample_before", 32'(sample_out), 32'(rom_word(18'd1001)));
    step(4'b0100, 1'b1, 1'b0);
    check_state("stop.abort", 1'b0, 18'd1002, 2'd0, 4'b0000, 4'b0000);
    check("stop.sample", 32'(sample_out), 32'd0);
    step(4'b0000, 1'b0, 1'b0);
    check_state("stop.after", 1'b0, 18'd1002, 2'd0, 4'b0000, 4'b0000);
    check("stop.done_cnt0", 32'(done_cnt[0]), 32'd1);

    // ---- asynchronous reset mid-play, no clock edge in between
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check_state("areset.start3", 1'b1, 18'd3000, 2'd3, 4'b0000, 4'b0000);
    play_ticks(1);
    check("areset.sample_before", 32'(sample_out), 32'(rom_word(18'd3000)));
    #2;
    Reset_n = 1'b0;
    #1;
    check_state("areset.async", 1'b0, 18'd0, 2'd0, 4'b0000, 4'b0000);
    check("areset.sample", 32'(sample_out), 32'd0);
    check("areset.fsm_state", 32'(fsm_state), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    check_state("areset.after", 1'b0, 18'd0, 2'd0, 4'b0000, 4'b0000);
    check("areset.done_cnt3", 32'(done_cnt[3]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
